// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch unit, decoder and immediate generator.
// Holds the fetch FSM state encoding, the canonical NOP and the base opcodes.
package riscv_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } fetch_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: latches PC into a request, loads IR/old_pc on ack; fetch_done 1 cycle after ack.
// Waits indefinitely on imem_ack (no timeout); fetch_start outside IDLE is dropped.
// FETCH_ALIGN_CHECK_EN: misaligned fetch goes to ERR and pulses fetch_err; else address bits [1:0] forced to 0.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_0000)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetch_start,
    input  logic             pc_we,
    input  logic [WIDTH-1:0] pc_next,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             imem_ack,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] old_pc,
    output logic             busy,
    output logic             fetch_done,
    output logic             fetch_err
);

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] old_pc_q, old_pc_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] fetch_addr;
    logic             misaligned;

`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic [WIDTH-1:0] RESET_ADDR = RESET_PC;
    assign fetch_addr = pc_we ? pc_next : pc_q;
    assign misaligned = |fetch_addr[1:0];
    assign fetch_err  = (state_q == S_ERR);
`else
    // Word-aligned memory only: drop the byte offset rather than trap.
    localparam logic [WIDTH-1:0] RESET_ADDR = RESET_PC & ~WIDTH'(3);
    assign fetch_addr = (pc_we ? pc_next : pc_q) & ~WIDTH'(3);
    assign misaligned = 1'b0;
    assign fetch_err  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            old_pc_q <= RESET_PC;
            instr_q  <= WIDTH'(NOP_INSTR);
            addr_q   <= RESET_ADDR;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            old_pc_q <= old_pc_d;
            instr_q  <= instr_d;
            addr_q   <= addr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_we ? pc_next : pc_q;
        old_pc_d = old_pc_q;
        instr_d  = instr_q;
        addr_d   = addr_q;
        case (state_q)
            S_IDLE: begin
                if (fetch_start) begin
                    addr_d  = fetch_addr;
                    state_d = misaligned ? S_ERR : S_REQ;
                end
            end
            S_REQ: begin
                if (imem_ack) begin
                    instr_d  = imem_rdata;
                    old_pc_d = addr_q;
                    // A redirect in the ack cycle overrides sequential advance.
                    if (!pc_we) begin
                        pc_d = addr_q + WIDTH'(4);
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign imem_req   = (state_q == S_REQ);
    assign busy       = (state_q == S_REQ);
    assign fetch_done = (state_q == S_DONE);
    assign imem_addr  = addr_q;
    assign instr      = instr_q;
    assign pc         = pc_q;
    assign old_pc     = old_pc_q;

endmodule
